// File: rtl/lu_issue.sv
// rtl/lu_issue.sv - issue/writeback stage driving the 64-bit logic unit select interface
module lu_issue #(
  parameter logic [5:0] LOGIC_OPC = 6'b000000,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  output logic [5:0]       lu_select,
  output logic [63:0]      lu_a,
  output logic [63:0]      lu_b,
  input  logic [63:0]      lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [4:0]       res_rd,
  output logic             res_err,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             busy
);

  logic             r_s1_valid;
  logic [4:0]       r_s1_rd;
  logic             r_s1_err;
  logic [5:0]       r_lu_select;
  logic [63:0]      r_lu_a;
  logic [63:0]      r_lu_b;
  logic             r_res_valid;
  logic [63:0]      r_res_data;
  logic [4:0]       r_res_rd;
  logic             r_res_err;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic             w_legal;
  logic             w_accept;
  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_unused_instr;

  // Logic-group opcode with a funct in the 100xxx block selects one of the eight LU ops
  assign w_legal        = (in_instr[31:26] == LOGIC_OPC) && (in_instr[5:3] == 3'b100);
  assign w_unused_instr = &{1'b0, in_instr[20:6]};

  assign w_s2_free = !r_res_valid || res_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;

  // S1: capture instruction; illegal ones drive a zero select and zero operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_rd     <= 5'd0;
      r_s1_err    <= 1'b0;
      r_lu_select <= 6'b000000;
      r_lu_a      <= 64'h0;
      r_lu_b      <= 64'h0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_rd     <= in_instr[25:21];
      r_s1_err    <= !w_legal;
      r_lu_select <= w_legal ? in_instr[5:0] : 6'b000000;
      r_lu_a      <= w_legal ? in_a : 64'h0;
      r_lu_b      <= w_legal ? in_b : 64'h0;
    end else if (w_s1_adv) begin
      // LU inputs deliberately hold their last values after the entry leaves
      r_s1_valid  <= 1'b0;
    end
  end

  // S2: capture the LU result (forced to zero for illegal entries) for writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 64'h0;
      r_res_rd    <= 5'd0;
      r_res_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_res_valid <= 1'b1;
      r_res_data  <= r_s1_err ? 64'h0 : lu_out;
      r_res_rd    <= r_s1_rd;
      r_res_err   <= r_s1_err;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_accept && !w_legal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign lu_select   = r_lu_select;
  assign lu_a        = r_lu_a;
  assign lu_b        = r_lu_b;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_rd      = r_res_rd;
  assign res_err     = r_res_err;
  assign illegal_cnt = r_illegal_cnt;
  assign busy        = r_s1_valid || r_res_valid;

endmodule

// File: tb/tb_lu_issue.sv
// tb/tb_lu_issue.sv - randomized and directed bench for lu_issue against a queue model
module tb_lu_issue;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [63:0]   in_a;
  logic [63:0]   in_b;
  logic [5:0]    lu_select;
  logic [63:0]   lu_a;
  logic [63:0]   lu_b;
  logic [63:0]   lu_out;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic [4:0]    res_rd;
  logic          res_err;
  logic [CW-1:0] illegal_cnt;
  logic          busy;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc, n_chk, n_pass, n_ret, m_cnt;
  logic [5:0]  m_sel;
  logic [63:0] m_a, m_b;

  always #5 clk = ~clk;

  // Behavioural logic unit; unknown selects give a marker so ungated results show up
  function automatic logic [63:0] ref_lu(input logic [5:0] sel, input logic [63:0] a, input logic [63:0] b);
    case (sel)
      6'b100000: return a & b;
      6'b100001: return a | b;
      6'b100010: return ~(a & b);
      6'b100011: return ~(a | b);
      6'b100100: return ~a;
      6'b100101: return 64'd0 - a;
      6'b100110: return a ^ b;
      6'b100111: return ~(a ^ b);
      default:   return 64'hDEADBEEF_DEADBEEF;
    endcase
  endfunction

  function automatic logic is_legal(input logic [31:0] ins);
    if (ins[31:26] != 6'b000000) return 1'b0;
    case (ins[5:0])
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign lu_out = ref_lu(lu_select, lu_a, lu_b);

  lu_issue #(.LOGIC_OPC(6'b000000), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_a(in_a), .in_b(in_b),
    .lu_select(lu_select), .lu_a(lu_a), .lu_b(lu_b), .lu_out(lu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err), .illegal_cnt(illegal_cnt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: drive at posedge+1, check at negedge, update model, end at next posedge+1
  task automatic tick(input logic v, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                      input logic rr, input logic use_exp, input logic [63:0] exp_d);
    logic exp_rdy, exp_rv;
    exp_t e;
    in_valid = v; in_instr = ins; in_a = a; in_b = b; res_ready = rr;
    @(negedge clk);
    exp_rdy = (q.size() < 2) || rr;
    exp_rv  = (q.size() > 0) && ((cyc - q[0].acc) >= 1);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("busy", {63'd0, busy}, {63'd0, q.size() > 0});
    chk("res_valid", {63'd0, res_valid}, {63'd0, exp_rv});
    chk("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
    chk("lu_select", 64'(lu_select), 64'(m_sel));
    chk("lu_a", lu_a, m_a);
    chk("lu_b", lu_b, m_b);
    if (exp_rv) begin
      chk("res_data", res_data, q[0].data);
      chk("res_rd", 64'(res_rd), 64'(q[0].rd));
      chk("res_err", {63'd0, res_err}, {63'd0, q[0].err});
      if (rr) begin
        void'(q.pop_front());
        n_ret++;
      end
    end
    if (v && exp_rdy) begin
      e.err  = !is_legal(ins);
      e.rd   = ins[25:21];
      e.data = e.err ? 64'h0 : (use_exp ? exp_d : ref_lu(ins[5:0], a, b));
      e.acc  = cyc + 1;
      q.push_back(e);
      if (e.err && m_cnt < (1 << CW) - 1) m_cnt++;
      m_sel = e.err ? 6'b000000 : ins[5:0];
      m_a   = e.err ? 64'h0 : a;
      m_b   = e.err ? 64'h0 : b;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
  endtask

  // Mid-cycle asynchronous reset; outputs must clear without waiting for a clock edge
  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_lu_select", 64'(lu_select), 64'd0);
    chk("rst_lu_a", lu_a, 64'd0);
    chk("rst_lu_b", lu_b, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_rd", 64'(res_rd), 64'd0);
    chk("rst_res_err", {63'd0, res_err}, 64'd0);
    chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    m_cnt = 0; m_sel = 6'b000000; m_a = 64'h0; m_b = 64'h0; cyc = 0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rd, input logic [5:0] fn);
    return {opc, rd, 15'd0, fn};
  endfunction

  logic [5:0]  sel_tab[8];
  logic [63:0] exp_tab[8];
  logic [31:0] r_ins;
  logic [5:0]  r_opc, r_fn;
  int          n0;

  initial begin
    n_chk = 0; n_pass = 0; n_ret = 0; cyc = 0; m_cnt = 0;
    m_sel = 6'b000000; m_a = 64'h0; m_b = 64'h0;
    rst_n = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_a = 64'h0; in_b = 64'h0; res_ready = 1'b1;
    sel_tab = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111};
    exp_tab = '{64'h000F000F000F000F, 64'h0FFF0FFF0FFF0FFF, 64'hFFF0FFF0FFF0FFF0, 64'hF000F000F000F000,
                64'hFF00FF00FF00FF00, 64'hFF00FF00FF00FF01, 64'h0FF00FF00FF00FF0, 64'hF00FF00FF00FF00F};
    @(posedge clk);
    #1;
    do_reset();

    // Each legal op back-to-back, then TCM of 1
    for (int i = 0; i < 8; i++)
      tick(1'b1, mk(6'b000000, 5'd7, sel_tab[i]), 64'h00FF00FF00FF00FF, 64'h0F0F0F0F0F0F0F0F, 1'b1, 1'b1, exp_tab[i]);
    tick(1'b1, mk(6'b000000, 5'd7, 6'b100101), 64'd1, 64'h0F0F0F0F0F0F0F0F, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    idle(3);

    // Illegal funct and illegal opcode interleaved with legal ops
    tick(1'b1, mk(6'b000000, 5'd1, 6'b100000), 64'hF0, 64'h3C, 1'b1, 1'b1, 64'h30);
    tick(1'b1, mk(6'b000000, 5'd2, 6'b101000), 64'h55, 64'hAA, 1'b1, 1'b0, 64'h0);
    tick(1'b1, mk(6'b000001, 5'd3, 6'b100000), 64'h55, 64'hAA, 1'b1, 1'b0, 64'h0);
    tick(1'b1, mk(6'b000000, 5'd4, 6'b100001), 64'hF0, 64'h0F, 1'b1, 1'b1, 64'hFF);
    idle(3);
    chk("illegal_cnt_two", 64'(illegal_cnt), 64'd2);

    // Backpressure: third instruction must wait until writeback accepts
    tick(1'b1, mk(6'b000000, 5'd11, 6'b100110), 64'h1, 64'h3, 1'b0, 1'b0, 64'h0);
    tick(1'b1, mk(6'b000000, 5'd12, 6'b100110), 64'h2, 64'h3, 1'b0, 1'b0, 64'h0);
    tick(1'b1, mk(6'b000000, 5'd13, 6'b100110), 64'h3, 64'h3, 1'b0, 1'b0, 64'h0);
    tick(1'b1, mk(6'b000000, 5'd13, 6'b100110), 64'h3, 64'h3, 1'b0, 1'b0, 64'h0);
    n0 = n_ret;
    tick(1'b1, mk(6'b000000, 5'd13, 6'b100110), 64'h3, 64'h3, 1'b1, 1'b0, 64'h0);
    idle(4);
    chk("bp_returned", 64'(n_ret - n0), 64'd3);

    // Streaming at full rate
    n0 = n_ret;
    for (int i = 0; i < 16; i++)
      tick(1'b1, mk(6'b000000, 5'(i), {3'b100, 3'($urandom)}), {$urandom, $urandom}, {$urandom, $urandom},
           1'b1, 1'b0, 64'h0);
    idle(2);
    chk("stream_count", 64'(n_ret - n0), 64'd16);

    // Reset with both stages full, then confirm normal latency afterwards
    tick(1'b1, mk(6'b000000, 5'd20, 6'b100000), 64'hFF, 64'hF, 1'b0, 1'b0, 64'h0);
    tick(1'b1, mk(6'b000000, 5'd21, 6'b100001), 64'hFF, 64'hF, 1'b0, 1'b0, 64'h0);
    tick(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    do_reset();
    tick(1'b1, mk(6'b000000, 5'd22, 6'b100011), 64'h1234, 64'h8765, 1'b1, 1'b0, 64'h0);
    idle(3);

    // Random traffic with random backpressure; counter saturates at 2^CW-1
    for (int i = 0; i < 400; i++) begin
      r_opc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'b000000;
      r_fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {3'b100, 3'($urandom)};
      r_ins = mk(r_opc, 5'($urandom), r_fn);
      tick(1'($urandom), r_ins, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
           1'b0, 64'h0);
    end
    idle(5);
    chk("drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
